wptr_full_ctrl: RTL and testbench
=================================

Name: wptr_full_ctrl

Overview:
Write-domain pointer and full-flag generator for the asynchronous FIFO. It is the write-side counterpart of the read pointer/empty logic.
- Maintains a dual binary/Gray write pointer.
- Drives the memory write address.
- Produces registered full, almost-full, fill-level and sticky overflow status from the read pointer that has already been synchronized into wclk.
- All logic runs on wclk; the synchronizers are outside this block.

Parameters:
ADDRSIZE, 9, memory address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
AFULL_MARGIN, 4, almost-full asserts when fill level >= 2**ADDRSIZE - AFULL_MARGIN; legal range 1..2**ADDRSIZE-1.

Ports:
wclk  input  1  write clock; all state updates on its rising edge.
wrst  input  1  synchronous, active-high reset.
winc  input  1  write request; accepted only when wfull=0.
wq2_rptr  input  ADDRSIZE+1  read pointer (Gray) after two-flop synchronization into wclk.
wclr_ovf  input  1  clears woverflow.
waddr  output  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
wptr  output  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wcount  output  ADDRSIZE+1  registered fill level as seen from the write domain (0..2**ADDRSIZE).
woverflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: one clock, single synchronous, active-high reset named wrst. While wrst=1 at a wclk edge it has priority over all other inputs:
  - wbin=0, wptr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0.
- Reset asserted mid-operation discards any in-flight winc and takes effect on that edge.
- Next binary pointer: wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
- Next Gray pointer: wgraynext = (wbinnext>>1) ^ wbinnext.
- Each edge loads {wbin, wptr} <= {wbinnext, wgraynext}. wptr is registered and changes at most one bit per edge.
- Full check:
  - wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - wfull <= wfull_val, so wfull asserts on the same edge that accepts the last free slot.
- Fill level:
  - rbin_s = Gray-to-binary of wq2_rptr (MSB copied, then XOR prefix down the bits).
  - wcount <= wbinnext - rbin_s, computed in ADDRSIZE+1 bits.
  - Conservative: it may overstate occupancy by up to the synchronizer latency, and never understates it.
- Almost-full: walmost_full <= (wbinnext - rbin_s) >= 2**ADDRSIZE - AFULL_MARGIN. It is also 1 whenever wfull_val=1.
- Write while full (winc=1 and wfull=1):
  - Pointer holds and waddr holds; no memory write is implied.
  - woverflow <= 1 on that edge.
- Overflow clear: wclr_ovf=1 clears woverflow on the next edge. If a set and a clear happen on the same edge, the set wins.
- Wrap-around: waddr wraps from 2**ADDRSIZE-1 to 0. The pointer MSB toggles every 2**ADDRSIZE writes, and the full compare relies on that MSB.
- Read side draining while full: wfull deasserts on the first edge after wq2_rptr changes (registered, one-cycle latency). It cannot deassert any earlier.
- Latency from a winc acceptance edge:
  - waddr and wptr update on that edge.
  - wcount, wfull and walmost_full reflect the write on that same edge.

Optional Feature:
- Macro: WPTR_ALMOST_FULL_EN.
- Defined: walmost_full is computed as described above.
- Undefined:
  - The walmost_full comparator and its register are not built; the walmost_full port is tied to 0.
  - AFULL_MARGIN is ignored.
  - All other behaviour is unchanged.

Test Plan:
(All scenarios use ADDRSIZE=4, AFULL_MARGIN=2, depth 16.)
1. Fill from reset: wrst pulse, wq2_rptr=5'b00000, 16 consecutive winc=1 -> after the 16th edge wfull=1, wptr=5'b11000, waddr=0, wcount=16. After the 15th edge wfull=0 and wcount=15.
2. Overflow: from state 1, winc=1 for 2 more cycles -> wptr stays 5'b11000, woverflow=1. Then wclr_ovf=1 together with winc=1 -> woverflow stays 1. Then wclr_ovf=1 with winc=0 -> woverflow=0.
3. Drain release: from full, set wq2_rptr=5'b00001 (binary 1), winc=0 -> next edge wfull=0, wcount=15, walmost_full=1.
4. Wrap: reader tracks the writer, with wq2_rptr=Gray(wbin-2) each cycle, for 40 writes -> wfull never asserts, waddr goes 15->0 twice, wptr after 32 writes equals 5'b00000.
5. Almost-full: from reset, 13 writes -> walmost_full=0; the 14th write -> walmost_full=1 on that edge. With WPTR_ALMOST_FULL_EN undefined, the same sequence keeps walmost_full=0.
6. Reset mid-operation: after 7 writes, assert wrst with winc=1 -> next edge wptr=0, waddr=0, wcount=0, wfull=0, woverflow=0. After wrst is released, the first winc gives wptr=5'b00001.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wptr_full_ctrl
//  Purpose  : Write-domain pointer and full-flag generator for an asynchronous
//             FIFO. Keeps a dual binary/Gray write pointer, drives the memory
//             write address and produces registered full, almost-full,
//             fill-level and sticky overflow status. The read pointer arrives
//             already synchronized into wclk.
//  Ports    : wclk          write clock (rising edge)
//             wrst          synchronous active-high reset
//             winc          write request, accepted only while wfull=0
//             wq2_rptr      synchronized read pointer (Gray, ADDRSIZE+1 bits)
//             wclr_ovf      clears woverflow
//             waddr         memory write address (ADDRSIZE bits)
//             wptr          registered Gray write pointer for the read domain
//             wfull         registered full flag
//             walmost_full  registered almost-full flag
//             wcount        registered fill level, 0..2**ADDRSIZE
//             woverflow     sticky flag: write attempted while full
//  Options  : WPTR_ALMOST_FULL_EN - when defined, the almost-full comparator
//             is built; otherwise walmost_full is tied to 0 and AFULL_MARGIN
//             has no effect.
//  Revision : 1.0 - initial release
// ============================================================================
module wptr_full_ctrl #(
  parameter int ADDRSIZE     = 9,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wclr_ovf,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] c_AFULL_THRESH =
    (ADDRSIZE+1)'((2**ADDRSIZE) - AFULL_MARGIN);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic              r_wfull;
  logic [ADDRSIZE:0] r_wcount;
  logic              r_woverflow;

  logic              w_accept;
  logic [ADDRSIZE:0] w_wbinnext;
  logic [ADDRSIZE:0] w_wgraynext;
  logic [ADDRSIZE:0] w_rbin_s;
  logic [ADDRSIZE:0] w_count_next;
  logic              w_wfull_val;
  logic              w_ovf_next;

  // A write is only accepted while the registered full flag is low.
  assign w_accept    = winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDRSIZE{1'b0}}, w_accept};
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi = gi + 1) begin : g_g2b
      assign w_rbin_s[gi] = ^wq2_rptr[ADDRSIZE:gi];
    end
  endgenerate

  // Full when the next write pointer equals the read pointer with its top two
  // Gray bits inverted: same address, one lap ahead.
  assign w_wfull_val  = (w_wgraynext ==
                         {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  // The synchronized read pointer lags the true one, so this difference can
  // only overstate occupancy.
  assign w_count_next = w_wbinnext - w_rbin_s;

  // Overflow set has priority over a simultaneous clear.
  assign w_ovf_next   = (winc & r_wfull) | (r_woverflow & ~wclr_ovf);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_wbin      <= '0;
      r_wptr      <= '0;
      r_wfull     <= 1'b0;
      r_wcount    <= '0;
      r_woverflow <= 1'b0;
    end else begin
      r_wbin      <= w_wbinnext;
      r_wptr      <= w_wgraynext;
      r_wfull     <= w_wfull_val;
      r_wcount    <= w_count_next;
      r_woverflow <= w_ovf_next;
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  logic r_walmost_full;
  logic w_afull_val;

  assign w_afull_val = (w_count_next >= c_AFULL_THRESH) | w_wfull_val;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_walmost_full <= 1'b0;
    end else begin
      r_walmost_full <= w_afull_val;
    end
  end

  assign walmost_full = r_walmost_full;
`else
  // Threshold is folded into a dead wire so the margin parameter stays
  // referenced when the comparator is not built.
  logic w_unused_afull;
  assign w_unused_afull = ^c_AFULL_THRESH;
  assign walmost_full   = 1'b0;
`endif

  assign waddr     = r_wbin[ADDRSIZE-1:0];
  assign wptr      = r_wptr;
  assign wfull     = r_wfull;
  assign wcount    = r_wcount;
  assign woverflow = r_woverflow;

endmodule
`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wptr_full_ctrl
//  Purpose  : Directed self-checking bench for wptr_full_ctrl with
//             ADDRSIZE=4, AFULL_MARGIN=2 (depth 16). Expected values are
//             hand-derived; almost-full expectations follow
//             WPTR_ALMOST_FULL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wptr_full_ctrl;

  localparam int c_AW = 4;

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic c_AF = 1'b1;
`else
  localparam logic c_AF = 1'b0;
`endif

  logic              wclk;
  logic              wrst;
  logic              winc;
  logic [c_AW:0]     wq2_rptr;
  logic              wclr_ovf;
  logic [c_AW-1:0]   waddr;
  logic [c_AW:0]     wptr;
  logic              wfull;
  logic              walmost_full;
  logic [c_AW:0]     wcount;
  logic              woverflow;

  int n_checks;
  int n_errors;

  wptr_full_ctrl #(
    .ADDRSIZE     (c_AW),
    .AFULL_MARGIN (2)
  ) u_dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wclr_ovf     (wclr_ovf),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic inc, input logic clr, input logic rst);
    winc     = inc;
    wclr_ovf = clr;
    wrst     = rst;
    @(posedge wclk);
    #1;
    winc     = 1'b0;
    wclr_ovf = 1'b0;
    wrst     = 1'b0;
  endtask

  function automatic logic [c_AW:0] gray(input logic [c_AW:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    logic [c_AW:0]   exp_bin;
    logic [c_AW-1:0] prev_addr;
    int              wraps;

    n_checks = 0;
    n_errors = 0;
    winc     = 1'b0;
    wclr_ovf = 1'b0;
    wrst     = 1'b0;
    wq2_rptr = '0;
    #2;

    // Reset state
    step(1'b0, 1'b0, 1'b1);
    check_val("rst_wptr",  32'(wptr),         32'h0);
    check_val("rst_waddr", 32'(waddr),        32'h0);
    check_val("rst_wfull", 32'(wfull),        32'h0);
    check_val("rst_wcnt",  32'(wcount),       32'h0);
    check_val("rst_ovf",   32'(woverflow),    32'h0);
    check_val("rst_afull", 32'(walmost_full), 32'h0);

    // 1. Fill from reset
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);
    check_val("fill15_wfull", 32'(wfull),  32'h0);
    check_val("fill15_wcnt",  32'(wcount), 32'd15);
    check_val("fill15_afull", 32'(walmost_full), 32'(c_AF));
    step(1'b1, 1'b0, 1'b0);
    check_val("fill16_wfull", 32'(wfull),  32'h1);
    check_val("fill16_wptr",  32'(wptr),   32'b11000);
    check_val("fill16_waddr", 32'(waddr),  32'h0);
    check_val("fill16_wcnt",  32'(wcount), 32'd16);
    check_val("fill16_afull", 32'(walmost_full), 32'(c_AF));
    check_val("fill16_ovf",   32'(woverflow), 32'h0);

    // 2. Overflow
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("ovf_wptr",  32'(wptr),      32'b11000);
    check_val("ovf_waddr", 32'(waddr),     32'h0);
    check_val("ovf_set",   32'(woverflow), 32'h1);
    check_val("ovf_wcnt",  32'(wcount),    32'd16);
    step(1'b1, 1'b1, 1'b0);
    check_val("ovf_setwins", 32'(woverflow), 32'h1);
    step(1'b0, 1'b1, 1'b0);
    check_val("ovf_clr",     32'(woverflow), 32'h0);
    check_val("ovf_clr_full", 32'(wfull),    32'h1);

    // 3. Drain release
    wq2_rptr = 5'b00001;
    step(1'b0, 1'b0, 1'b0);
    check_val("drain_wfull", 32'(wfull),        32'h0);
    check_val("drain_wcnt",  32'(wcount),       32'd15);
    check_val("drain_afull", 32'(walmost_full), 32'(c_AF));
    check_val("drain_wptr",  32'(wptr),         32'b11000);

    // 5. Almost-full threshold (16-2 = 14)
    wq2_rptr = '0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0);
    check_val("af13_afull", 32'(walmost_full), 32'h0);
    check_val("af13_wcnt",  32'(wcount),       32'd13);
    step(1'b1, 1'b0, 1'b0);
    check_val("af14_afull", 32'(walmost_full), 32'(c_AF));
    check_val("af14_wfull", 32'(wfull),        32'h0);

    // 4. Wrap with reader trailing by two
    step(1'b0, 1'b0, 1'b1);
    exp_bin = '0;
    wraps   = 0;
    for (int i = 0; i < 40; i++) begin
      prev_addr = waddr;
      wq2_rptr  = gray(exp_bin - 5'd2);
      step(1'b1, 1'b0, 1'b0);
      exp_bin = exp_bin + 5'd1;
      if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
      check_val("wrap_wfull", 32'(wfull),  32'h0);
      check_val("wrap_wcnt",  32'(wcount), 32'd3);
      check_val("wrap_wptr",  32'(wptr),   32'(gray(exp_bin)));
      if (i == 31) check_val("wrap32_wptr", 32'(wptr), 32'h0);
    end
    check_val("wrap_count", 32'(wraps), 32'd2);
    check_val("wrap_waddr", 32'(waddr), 32'd8);

    // 6. Reset mid-operation
    wq2_rptr = '0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    check_val("pre_rst_wptr", 32'(wptr), 32'b00100);
    step(1'b1, 1'b0, 1'b1);
    check_val("midrst_wptr",  32'(wptr),      32'h0);
    check_val("midrst_waddr", 32'(waddr),     32'h0);
    check_val("midrst_wcnt",  32'(wcount),    32'h0);
    check_val("midrst_wfull", 32'(wfull),     32'h0);
    check_val("midrst_ovf",   32'(woverflow), 32'h0);
    step(1'b1, 1'b0, 1'b0);
    check_val("post_rst_wptr",  32'(wptr),  32'b00001);
    check_val("post_rst_waddr", 32'(waddr), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
